xor_gate: RTL and testbench
===========================

XOR_GATE -- requirements
Module: xor_gate

Interface
REQ-001 Parameter CNT_W, default 16, width of the mismatch counter (legal range 2..32).
REQ-002 clk  input  1  single rising-edge clock for all registered logic.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 a  input  1  operand A.
REQ-005 b  input  1  operand B.
REQ-006 en  input  1  sample enable; registered state updates only when en=1.
REQ-007 clr  input  1  synchronous clear of y_q, parity, diff_cnt and cnt_sat.
REQ-008 y  output  1  combinational a XOR b.
REQ-009 y_q  output  1  registered copy of y.
REQ-010 y_rise  output  1  one-cycle pulse when y_q goes 0->1.
REQ-011 y_fall  output  1  one-cycle pulse when y_q goes 1->0.
REQ-012 parity  output  1  running XOR of every sampled y since the last reset or clear.
REQ-013 diff_cnt  output  CNT_W  count of sampled cycles with a != b.
REQ-014 cnt_sat  output  1  high while diff_cnt is at all-ones.

Function
REQ-015 y SHALL equal a XOR b at all times with zero clock latency, independent of clk, rst_n, en and clr: 00->0, 01->1, 10->1, 11->0.
REQ-016 X or Z on a or b SHALL propagate to y as X; registered outputs are undefined only while the inputs are unknown during a sampled edge.
REQ-017 On a rising edge with en=1 and clr=0: y_q <= y; parity <= parity XOR y; diff_cnt <= diff_cnt+1 if y=1 and the counter is not saturated.
REQ-018 diff_cnt SHALL saturate at 2^CNT_W-1 and never wrap; cnt_sat = (diff_cnt == all-ones), combinational from the register.
REQ-019 With en=0 and clr=0, all registered state SHALL hold.
REQ-020 clr=1 SHALL take priority over en: at the edge, y_q, parity, diff_cnt and cnt_sat become 0.
REQ-021 y_rise and y_fall SHALL be registered pulses, each exactly one cycle wide, reflecting the y_q transition on that same edge; they are never both high.
REQ-022 A clr that drops y_q from 1 to 0 SHALL NOT assert y_fall; both pulses are 0 in a clear cycle.
REQ-023 With en=0, y_rise and y_fall SHALL be 0 on the next cycle.
REQ-024 The outputs y_q, parity and diff_cnt are updated after 1 clock of latency from the sampled a and b.

Reset
REQ-025 When rst_n=0, all registered outputs SHALL go to 0 immediately, without waiting for clk: y_q, y_rise, y_fall, parity, diff_cnt and cnt_sat.
REQ-026 y SHALL remain purely combinational during reset.
REQ-027 Reset deassertion SHALL be taken synchronously via the normal edge; the first update occurs on the first rising edge with rst_n=1.
REQ-028 If reset is asserted mid-count, all state is discarded and no pulse is produced on release.

Structure
REQ-029 Package xor_gate_pkg SHALL hold the CNT_W default constant and a saturating-increment function.
REQ-030 Sub-module xor_cell SHALL implement the combinational 2-input XOR and be instantiated once for y.
REQ-031 The registered logic SHALL be a single always block sensitive to posedge clk and negedge rst_n; there SHALL be no latches.

Verification
REQ-032 No clock toggling: apply a,b = 00,01,10,11 at 1-time-unit steps -> y = 0,1,1,0 at each step.
REQ-033 After reset, en=1 for 4 cycles with ab = 01,11,10,10 -> y_q = 1,0,1,1; y_fall in cycle 2; y_rise in cycle 3; diff_cnt=3; parity=1.
REQ-034 CNT_W=2, en=1, a=1, b=0 for 5 cycles -> diff_cnt = 1,2,3,3,3; cnt_sat=1 from cycle 3 on.
REQ-035 With diff_cnt=3, assert clr and en together -> next cycle diff_cnt=0, parity=0, y_q=0, y_fall=0.
REQ-036 With en=0, toggle a and b for 3 cycles -> y follows the inputs; y_q, parity and diff_cnt are unchanged; pulses are 0.
REQ-037 Drive rst_n low between clock edges with diff_cnt=5 -> all registered outputs read 0 before the next edge, and y is still a XOR b.

Source files
------------

// File: rtl/xor_gate_pkg.sv
// xor_gate shared constants and helpers.
// Counter width default and saturating increment.
package xor_gate_pkg;

  localparam int CNT_W_DEF = 16;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max,
    input logic        inc
  );
    if (inc && (v != max))
      return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/xor_gate_xor_cell.sv
// Two-input combinational XOR cell.
// X/Z on either operand propagates as X.
module xor_cell (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_gate.sv
// XOR gate with registered copy, edge pulses,
// running parity and saturating mismatch counter.
module xor_gate
  import xor_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             en,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic             y_fall,
  output logic             parity,
  output logic [CNT_W-1:0] diff_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             yq_q,   yq_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             par_q,  par_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  xor_cell u_cell (
    .a_i (a),
    .b_i (b),
    .y_o (y)
  );

  always_comb begin
    yq_d   = yq_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    par_d  = par_q;
    cnt_d  = cnt_q;
    // clear wins over enable and suppresses both pulses
    if (clr) begin
      yq_d  = 1'b0;
      par_d = 1'b0;
      cnt_d = '0;
    end else if (en) begin
      yq_d   = y;
      rise_d = ~yq_q & y;
      fall_d = yq_q & ~y;
      par_d  = par_q ^ y;
      cnt_d  = CNT_W'(sat_inc(32'(cnt_q),
                              32'(CNT_MAX), y));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yq_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      par_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      yq_q   <= yq_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      par_q  <= par_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y_q      = yq_q;
  assign y_rise   = rise_q;
  assign y_fall   = fall_q;
  assign parity   = par_q;
  assign diff_cnt = cnt_q;
  assign cnt_sat  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_xor_gate.sv
// Scoreboard bench for xor_gate: stimulus pushes
// expected state, a monitor pops and compares.
module tb_xor_gate;

  localparam int W   = 3;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a = 1'b0, b = 1'b0;
  logic         en = 1'b0, clr = 1'b0;
  logic         y, y_q, y_rise, y_fall;
  logic         parity, cnt_sat;
  logic [W-1:0] diff_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       yq;
    logic       rise;
    logic       fall;
    logic       par;
    logic [7:0] cnt;
    logic       sat;
  } exp_t;

  exp_t q[$];

  int m_yq   = 0;
  int m_ones = 0;
  int m_cnt  = 0;

  xor_gate #(.CNT_W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .en       (en),
    .clr      (clr),
    .y        (y),
    .y_q      (y_q),
    .y_rise   (y_rise),
    .y_fall   (y_fall),
    .parity   (parity),
    .diff_cnt (diff_cnt),
    .cnt_sat  (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, ".y_q"},     32'(y_q),      0);
    chk({tag, ".rise"},    32'(y_rise),   0);
    chk({tag, ".fall"},    32'(y_fall),   0);
    chk({tag, ".parity"},  32'(parity),   0);
    chk({tag, ".cnt"},     32'(diff_cnt), 0);
    chk({tag, ".sat"},     32'(cnt_sat),  0);
  endtask

  task automatic model_reset();
    m_yq   = 0;
    m_ones = 0;
    m_cnt  = 0;
  endtask

  // One clock of stimulus; expected post-edge state is queued.
  task automatic cyc(input logic ai, input logic bi,
                     input logic ei, input logic ci);
    exp_t e;
    int   yv;
    @(negedge clk);
    a = ai; b = bi; en = ei; clr = ci;
    #1;
    yv = (ai != bi) ? 1 : 0;
    chk("y_comb", 32'(y), 32'(yv));
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (ci) begin
      model_reset();
    end else if (ei) begin
      e.rise = (m_yq == 0 && yv == 1);
      e.fall = (m_yq == 1 && yv == 0);
      m_yq   = yv;
      m_ones = m_ones + yv;
      m_cnt  = (m_cnt + yv > MAX) ? MAX : m_cnt + yv;
    end
    if (ci) m_ones = 0;
    e.yq  = m_yq[0];
    e.par = m_ones[0];
    e.cnt = 8'(m_cnt);
    e.sat = (m_cnt == MAX);
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("y_q",      32'(y_q),      32'(e.yq));
        chk("y_rise",   32'(y_rise),   32'(e.rise));
        chk("y_fall",   32'(y_fall),   32'(e.fall));
        chk("parity",   32'(parity),   32'(e.par));
        chk("diff_cnt", 32'(diff_cnt), 32'(e.cnt));
        chk("cnt_sat",  32'(cnt_sat),  32'(e.sat));
      end
    end
  end

  initial begin : stim
    logic [3:0] ab_tab;
    int         wait_cyc;
    #2;
    chk_regs_zero("rst");
    // combinational truth table, 1-unit steps
    for (int i = 0; i < 4; i++) begin
      ab_tab = 4'(i);
      a = ab_tab[1];
      b = ab_tab[0];
      #1;
      chk("y_tt", 32'(y), 32'(ab_tab[1] ^ ab_tab[0]));
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    // clear together with enable while y_q=1
    cyc(1, 0, 1, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 0);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(i[0], ~i[0], 0, 0);
    cyc(0, 1, 1, 1);

    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0);

    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    a = 1'b1; b = 1'b0; en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_regs_zero("arst");
    chk("y_in_rst", 32'(y), 1);
    model_reset();
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 5) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    chk("drain", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
